vga_timing_compositor: RTL and testbench

//  Generates 640x480@60 VGA timing and the hcount/vcount/xcoord/ycoord/active raster that drives
//  the sprite renderers. Composites two player layers over a background colour, then drives the
//  DAC pins. Delay-aligns sync/blank to the registered ROM latency of the pixel sources.

---
 rtl/vga_timing_compositor.sv | 153 +++++++++++++++
 tb/tb_vga_timing_compositor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_compositor.sv
// 640x480@60 VGA raster generator with a two-layer colour-keyed compositor.
// Sync/blank are delayed to line up with the registered pixel sources, then everything is registered to the DAC pins.
module vga_timing_compositor #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WAIT   = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WAIT   = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int COLOR_DEPTH   = 8,
  parameter int PIPE_DELAY    = 1,
  parameter logic [COLOR_DEPTH-1:0] TRANSPARENT = 8'hE3,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR    = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [9:0]             hcount,
  output logic [9:0]             vcount,
  output logic [9:0]             xcoord,
  output logic [9:0]             ycoord,
  output logic                   active,
  output logic                   frame_start,
  input  logic [COLOR_DEPTH-1:0] p1_color,
  input  logic                   p1_active,
  input  logic [COLOR_DEPTH-1:0] p2_color,
  input  logic                   p2_active,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_WAIT + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_WAIT + V_BACK_PORCH;
  localparam int H_ACT   = H_SYNC_WAIT + H_BACK_PORCH;
  localparam int V_ACT   = V_SYNC_WAIT + V_BACK_PORCH;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT0  = 10'(H_ACT);
  localparam logic [9:0] H_ACT1  = 10'(H_ACT + H_VISIBLE);
  localparam logic [9:0] V_ACT0  = 10'(V_ACT);
  localparam logic [9:0] V_ACT1  = 10'(V_ACT + V_VISIBLE);
  localparam logic [9:0] H_SYNC  = 10'(H_SYNC_WAIT);
  localparam logic [9:0] V_SYNC  = 10'(V_SYNC_WAIT);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       act_next;

  // Raster outputs are computed from the next counter state so all of them
  // register together and describe the same pixel.
  always_comb begin
    h_next = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
    act_next = (h_next >= H_ACT0) && (h_next < H_ACT1) &&
               (v_next >= V_ACT0) && (v_next < V_ACT1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      xcoord      <= '0;
      ycoord      <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      active      <= act_next;
      xcoord      <= act_next ? h_next - H_ACT0 : 10'd0;
      ycoord      <= act_next ? v_next - V_ACT0 : 10'd0;
      // Pulse only on a real wrap, never on the reset-to-zero load.
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

  sync_t raw;
  sync_t dly [PIPE_DELAY];
  sync_t aligned;

  always_comb begin
    raw.hs  = (hcount >= H_SYNC);
    raw.vs  = (vcount >= V_SYNC);
    raw.act = active;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= SYNC_IDLE;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  assign aligned = dly[PIPE_DELAY-1];

  logic                   p1_opaque;
  logic                   p2_opaque;
  logic [COLOR_DEPTH-1:0] mix;

  // Layer inputs are only looked at inside the visible area, so undriven
  // renderer outputs during blanking can never reach the DAC.
  always_comb begin
    p1_opaque = p1_active && (p1_color != TRANSPARENT);
    p2_opaque = p2_active && (p2_color != TRANSPARENT);
    mix       = '0;
    if (aligned.act) begin
      if (p1_opaque)      mix = p1_color;
      else if (p2_opaque) mix = p2_color;
      else                mix = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= aligned.hs;
      vga_vs      <= aligned.vs;
      vga_blank_n <= aligned.act;
      vga_r       <= {mix[7:5], mix[7:5], mix[7:6]};
      vga_g       <= {mix[4:2], mix[4:2], mix[4:3]};
      vga_b       <= {mix[1:0], mix[1:0], mix[1:0], mix[1:0]};
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Bench for vga_timing_compositor: default horizontal timing, shortened frame height,
// random layer stimulus checked every cycle against an arithmetic raster/pixel model.
module tb_vga_timing_compositor;

  localparam int HT    = 800;
  localparam int VV    = 12;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 4;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int MID_N = 2 * FRAME + 10 * HT + 400;

  logic       clk;
  logic       reset;
  logic [9:0] hcount, vcount, xcoord, ycoord;
  logic       active, frame_start;
  logic [7:0] p1_color, p2_color;
  logic       p1_active, p2_active;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_timing_compositor #(
    .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_WAIT(VS), .V_BACK_PORCH(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .hcount(hcount), .vcount(vcount), .xcoord(xcoord), .ycoord(ycoord),
    .active(active), .frame_start(frame_start),
    .p1_color(p1_color), .p1_active(p1_active),
    .p2_color(p2_color), .p2_active(p2_active),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: n = cycles since the last reset edge; r0/r1/r2 = raster index
  // of this, previous and two-ago cycle (-1 means the blanked reset state)
  int   n = 0;
  int   r0 = -1, r1 = -1, r2 = -1;
  bit   started = 0;
  bit   rst_last = 0;
  logic [7:0] d_p1c = 0, d_p2c = 0;
  logic       d_p1a = 0, d_p2a = 0;

  int hs_low = 0, vs_low = 0, fs_cnt = 0;
  bit mid_done = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, got, want);
    end
  endtask

  function automatic logic [7:0] expand3(input int c3);
    return 8'((c3 * 255 + 3) / 7);
  endfunction

  function automatic logic [41:0] raster_exp(input int m);
    int h, v, x, y;
    bit act, fs;
    h   = m % HT;
    v   = (m / HT) % VT;
    act = (h >= 144) && (h < 784) && (v >= VS + VB) && (v < VS + VB + VV);
    x   = act ? h - 144 : 0;
    y   = act ? v - (VS + VB) : 0;
    fs  = (m > 0) && (h == 0) && (v == 0);
    return {10'(h), 10'(v), 10'(x), 10'(y), act, fs};
  endfunction

  function automatic logic [27:0] pins_exp(input int m, input logic [7:0] c1, input logic a1,
                                           input logic [7:0] c2, input logic a2);
    int h, v, c;
    bit act, hs, vs;
    if (m < 0) return {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    h   = m % HT;
    v   = (m / HT) % VT;
    hs  = (h >= 96);
    vs  = (v >= VS);
    act = (h >= 144) && (h < 784) && (v >= VS + VB) && (v < VS + VB + VV);
    if (!act)                      c = 0;
    else if (a1 && c1 != 8'hE3)    c = int'(c1);
    else if (a2 && c2 != 8'hE3)    c = int'(c2);
    else                           c = 0;
    return {hs, vs, act, 1'b0, expand3(c / 32), expand3((c / 4) % 8), 8'((c % 4) * 85)};
  endfunction

  // driver + compare: one call per clock cycle
  task automatic step(input bit rst, input int mode);
    logic [27:0] want_pins;
    @(negedge clk);
    if (rst_last) begin
      n = 0; r0 = 0; r1 = -1; r2 = -1;
      started = 1;
    end else begin
      n++; r2 = r1; r1 = r0; r0 = n;
    end
    if (started) begin
      check("raster", {hcount, vcount, xcoord, ycoord, active, frame_start}, raster_exp(r0));
      want_pins = rst_last ? pins_exp(-1, 0, 0, 0, 0) : pins_exp(r2, d_p1c, d_p1a, d_p2c, d_p2a);
      check("pins", {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b}, want_pins);
    end
    reset = rst;
    case (mode)
      1: begin p1_active = 1; p1_color = 8'h1C; p2_active = 1; p2_color = 8'hE0; end
      2: begin p1_active = 1; p1_color = 8'hE3; p2_active = 1; p2_color = 8'h03; end
      3: begin p1_active = 0; p1_color = 8'($urandom); p2_active = 0; p2_color = 8'($urandom); end
      default: begin
        p1_active = 1'($urandom_range(0, 1));
        p2_active = 1'($urandom_range(0, 1));
        p1_color  = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
        p2_color  = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
      end
    endcase
    rst_last = rst;
    d_p1c = p1_color; d_p1a = p1_active; d_p2c = p2_color; d_p2a = p2_active;
  endtask

  initial begin
    int  mode;
    bit  rst;
    reset = 1; p1_color = 0; p2_color = 0; p1_active = 0; p2_active = 0;
    for (int i = 0; i < 3; i++) step(1, 0);

    for (int k = 0; k < MID_N + 2200 && errors < 50; k++) begin
      mode = 0;
      if (!mid_done) begin
        if (n >= FRAME + 8 * HT && n < FRAME + 9 * HT)        mode = 1;
        else if (n >= FRAME + 9 * HT && n < FRAME + 10 * HT)  mode = 2;
        else if (n >= FRAME + 10 * HT && n < FRAME + 11 * HT) mode = 3;
      end
      rst = (!mid_done && n == MID_N);
      if (rst) mid_done = 1;
      step(rst, mode);

      // hand-computed points
      if (n == 0) begin
        check("reset_state", {hcount, vcount, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'h0});
      end
      if (!mid_done) begin
        if (vga_hs == 1'b0 && n >= 800 && n < 1600) hs_low++;
        if (vga_vs == 1'b0 && n >= FRAME && n < 2 * FRAME) vs_low++;
        if (frame_start) fs_cnt++;
        case (n)
          799:  check("h_wrap_pre",  {hcount, vcount}, {10'd799, 10'd0});
          800:  check("h_wrap_post", {hcount, vcount}, {10'd0, 10'd1});
          801:  check("hs_before",   vga_hs, 1'b1);
          802:  check("hs_fall",     vga_hs, 1'b0);
          897:  check("hs_last_low", vga_hs, 1'b0);
          898:  check("hs_rise",     vga_hs, 1'b1);
          1600: check("hs_low_cycles", 64'(hs_low), 64'd96);
          6 * HT + 143: check("act_before", active, 1'b0);
          6 * HT + 144: check("act_first", {active, xcoord, ycoord}, {1'b1, 10'd0, 10'd0});
          17 * HT + 783: check("act_last", {active, xcoord, ycoord}, {1'b1, 10'd639, 10'd11});
          17 * HT + 784: check("act_after", active, 1'b0);
          FRAME: check("frame_pulse", frame_start, 1'b1);
          FRAME + 8 * HT + 400: check("p1_over_p2", {vga_blank_n, vga_r, vga_g, vga_b},
                                      {1'b1, 24'h00FF00});
          FRAME + 9 * HT + 400: check("key_shows_p2", {vga_blank_n, vga_r, vga_g, vga_b},
                                      {1'b1, 24'h0000FF});
          FRAME + 10 * HT + 400: check("background", {vga_blank_n, vga_r, vga_g, vga_b},
                                       {1'b1, 24'h000000});
          2 * FRAME: check("vs_low_cycles", 64'(vs_low), 64'(VS * HT));
          2 * FRAME + 1: check("frame_pulse_count", 64'(fs_cnt), 64'd2);
          default: ;
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
